// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, grant encodings, default width.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_VID  = 2'd2,
    GNT_CPU  = 2'd3
  } grant_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Command/response bus between the arbiter (master) and the SDRAM controller (slave).
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_be;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/sdram_arb_select.sv
// Winner select: loader first, then a starved CPU, then video, then CPU.
module sdram_arb_select
  import sdram_arb_pkg::*;
(
  input  logic   ld_req,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   cpu_starved,
  output grant_t winner
);

  always_comb begin
    winner = GNT_NONE;
    if (ld_req)                        winner = GNT_LD;
    else if (cpu_req && cpu_starved)   winner = GNT_CPU;
    else if (vid_req)                  winner = GNT_VID;
    else if (cpu_req)                  winner = GNT_CPU;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between loader, video and CPU, one transaction at a time.
// Define SDRAM_ARB_PERF_EN to add per-requester ack counters and the worst CPU wait.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk_ram,
  input  logic                reset_n,
  input  logic                ld_req,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [15:0]         ld_wdata,
  input  logic [1:0]          ld_be,
  output logic                ld_ack,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic [15:0]         vid_rdata,
  output logic                vid_ack,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [15:0]         cpu_wdata,
  input  logic [1:0]          cpu_be,
  output logic [15:0]         cpu_rdata,
  output logic                cpu_ack,
  sdram_port_arbiter_if.master mem,
  output logic [1:0]          grant
`ifdef SDRAM_ARB_PERF_EN
  ,
  output logic [15:0]         perf_ld_cnt,
  output logic [15:0]         perf_vid_cnt,
  output logic [15:0]         perf_cpu_cnt,
  output logic [15:0]         perf_max_cpu_wait
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d, winner;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [15:0]       vid_rdata_q, vid_rdata_d;
  logic [15:0]       cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              starved, cpu_win, rd_done, issue;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  sdram_arb_select u_select (
    .ld_req      (ld_req),
    .vid_req     (vid_req),
    .cpu_req     (cpu_req),
    .cpu_starved (starved),
    .winner      (winner)
  );

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
      starve_q    <= '0;
    end else begin
      // NOTE: sequential state is only ever assigned with <=.
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      starve_q    <= starve_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no latch is inferred.
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner != GNT_NONE) begin
          state_d = ISSUE;
          grant_d = winner;
          case (winner)
            GNT_LD: begin
              addr_d = ld_addr;  wdata_d = ld_wdata;  be_d = ld_be;  we_d = 1'b1;
            end
            GNT_VID: begin
              addr_d = vid_addr; wdata_d = '0;        be_d = 2'b11;  we_d = 1'b0;
            end
            GNT_CPU: begin
              addr_d = cpu_addr; wdata_d = cpu_wdata; be_d = cpu_be; we_d = cpu_we;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        if (mem.mem_ready) begin
          if (we_q) begin
            state_d = DONE;
          end else if (mem.mem_rvalid) begin
            rd_done = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem.mem_rvalid) begin
          rd_done = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read capture and CPU starvation tracking.
  always_comb begin
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    if (rd_done && grant_q == GNT_VID) vid_rdata_d = mem.mem_rdata;
    if (rd_done && grant_q == GNT_CPU) cpu_rdata_d = mem.mem_rdata;

    cpu_win = (state_q == IDLE) && (winner == GNT_CPU);
    if (!cpu_req || grant_q == GNT_CPU || cpu_win) starve_d = '0;
    else if (!starved)                             starve_d = starve_q + CNT_W'(1);
    else                                           starve_d = starve_q;
  end

  always_comb begin
    issue   = (state_q == ISSUE);
    ld_ack  = (state_q == DONE) && (grant_q == GNT_LD);
    vid_ack = (state_q == DONE) && (grant_q == GNT_VID);
    cpu_ack = (state_q == DONE) && (grant_q == GNT_CPU);
  end

  // Command fields are gated so the bus reads all-zero outside ISSUE.
  assign mem.mem_req   = issue;
  assign mem.mem_we    = issue & we_q;
  assign mem.mem_addr  = issue ? addr_q  : '0;
  assign mem.mem_wdata = issue ? wdata_q : '0;
  assign mem.mem_be    = issue ? be_q    : '0;

  assign vid_rdata = vid_rdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign grant     = grant_q;

`ifdef SDRAM_ARB_PERF_EN
  logic [15:0] perf_ld_q, perf_vid_q, perf_cpu_q, max_wait_q, cur_wait_q;
  logic        cpu_busy_q;

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      perf_ld_q  <= '0;
      perf_vid_q <= '0;
      perf_cpu_q <= '0;
      max_wait_q <= '0;
      cur_wait_q <= '0;
      cpu_busy_q <= 1'b0;
    end else begin
      if (ld_ack)  perf_ld_q  <= perf_ld_q  + 16'd1;
      if (vid_ack) perf_vid_q <= perf_vid_q + 16'd1;
      if (cpu_ack) perf_cpu_q <= perf_cpu_q + 16'd1;
      // A held cpu_req after an ack counts as the start of a new request.
      if (cpu_ack) begin
        cpu_busy_q <= 1'b0;
        if (cur_wait_q > max_wait_q) max_wait_q <= cur_wait_q;
      end else if (cpu_busy_q) begin
        if (cur_wait_q != 16'hFFFF) cur_wait_q <= cur_wait_q + 16'd1;
      end else if (cpu_req) begin
        cpu_busy_q <= 1'b1;
        cur_wait_q <= 16'd1;
      end
    end
  end

  assign perf_ld_cnt       = perf_ld_q;
  assign perf_vid_cnt      = perf_vid_q;
  assign perf_cpu_cnt      = perf_cpu_q;
  assign perf_max_cpu_wait = max_wait_q;
`endif

endmodule
